seg_scan_capture: RTL and testbench

- Receive side of the multiplexed 7-segment display interface: samples the scanned cathodes/anodes lines of the display driver and rebuilds the complete 8-digit frame.
- Decodes each digit's segment pattern back to a hex nibble and flags scan errors.
- Used as an on-chip monitor / loopback checker beside the display driver, in the same clock domain as the board clock, or with the lines sampled asynchronously.

---
 rtl/seg_scan_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 12 +
 rtl/seg_scan_capture.sv | 132 +++++++++++++
 tb/tb_seg_scan_capture.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, glyph table, FSM states and pattern-to-nibble helper for
// the 7-segment scan receiver.
package seg_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the a..g pattern (1 = lit) of hex digit n.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } scan_state_t;

  // Returns {ok, nibble}; unknown patterns give {0, 0}.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] hex
);

  assign {ok, hex} = seg_to_hex(seg[SEG_G:SEG_A]);

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment display: rebuilds the full frame
// from scanned anode/cathode lines, decodes each digit and flags scan errors.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int SETTLE        = 4,
  parameter int ANODE_ACT_LOW = 1,
  parameter int SEG_ACT_LOW   = 1,
  parameter int TIMEOUT       = 2**20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cathodes,
  input  logic [DIGITS-1:0]     anodes,
  output logic [8*DIGITS-1:0]   frame_seg,
  output logic [4*DIGITS-1:0]   frame_hex,
  output logic [DIGITS-1:0]     frame_ok,
  output logic                  frame_valid,
  output logic                  err_multi,
  output logic                  stale
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [3:0] SETTLE_MAX  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] CAT_IDLE = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_IDLE =
    (ANODE_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [7:0]           cat_s1_reg, cat_s2_reg;
  logic [DIGITS-1:0]    an_s1_reg, an_s2_reg;
  logic [DIGITS-1:0]    an_prev_reg;
  logic [3:0]           settle_cnt_reg;
  scan_state_t          state_reg;
  logic [DIGITS-1:0]    seen_reg;
  logic [8*DIGITS-1:0]  shadow_seg_reg;
  logic [4*DIGITS-1:0]  shadow_hex_reg;
  logic [DIGITS-1:0]    shadow_ok_reg;
  logic [TW-1:0]        timeout_cnt_reg;

  logic [7:0]        cat_n;
  logic [DIGITS-1:0] an_n;
  logic              change, eval, one_hot, multi_hot, capture, done;
  logic              dec_ok;
  logic [3:0]        dec_hex;

  // Synchronisers reset to the idle line level so the normalised view starts blank.
  assign cat_n = cat_s2_reg ^ CAT_IDLE;
  assign an_n  = an_s2_reg ^ AN_IDLE;

  assign change    = (an_n != an_prev_reg);
  assign one_hot   = (an_n != '0) && ((an_n & (an_n - AN_ONE)) == '0);
  assign multi_hot = (an_n != '0) && !one_hot;
  // Evaluation fires SETTLE cycles after the change cycle with no further change.
  assign eval      = (state_reg == ST_SETTLE) && !change && (settle_cnt_reg == SETTLE_LAST);
  assign capture   = eval && one_hot;
  assign done      = &seen_reg;
  assign stale     = (timeout_cnt_reg == TO_MAX);

  seg7_decode u_decode (
    .seg (cat_n[6:0]),
    .ok  (dec_ok),
    .hex (dec_hex)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cat_s1_reg      <= CAT_IDLE;
      cat_s2_reg      <= CAT_IDLE;
      an_s1_reg       <= AN_IDLE;
      an_s2_reg       <= AN_IDLE;
      an_prev_reg     <= '0;
      settle_cnt_reg  <= '0;
      state_reg       <= ST_WAIT;
      seen_reg        <= '0;
      shadow_seg_reg  <= '0;
      shadow_hex_reg  <= '0;
      shadow_ok_reg   <= '0;
      timeout_cnt_reg <= '0;
      frame_seg       <= '0;
      frame_hex       <= '0;
      frame_ok        <= '0;
      frame_valid     <= 1'b0;
      err_multi       <= 1'b0;
    end else begin
      cat_s1_reg  <= cathodes;
      cat_s2_reg  <= cat_s1_reg;
      an_s1_reg   <= anodes;
      an_s2_reg   <= an_s1_reg;
      an_prev_reg <= an_n;

      if (change)
        settle_cnt_reg <= '0;
      else if (settle_cnt_reg != SETTLE_MAX)
        settle_cnt_reg <= settle_cnt_reg + 4'd1;

      case (state_reg)
        ST_WAIT:   if (change) state_reg <= ST_SETTLE;
        ST_SETTLE: if (eval)   state_reg <= ST_HELD;
        ST_HELD:   if (change) state_reg <= ST_SETTLE;
        default:   state_reg <= ST_WAIT;
      endcase

      err_multi <= eval && multi_hot;

      for (int i = 0; i < DIGITS; i++) begin
        if (capture && an_n[i]) begin
          shadow_seg_reg[8*i +: 8] <= cat_n;
          shadow_hex_reg[4*i +: 4] <= dec_hex;
          shadow_ok_reg[i]         <= dec_ok;
        end
      end

      // A capture landing on the completion cycle starts the next frame's mask.
      seen_reg    <= (done ? '0 : seen_reg) | (capture ? an_n : '0);
      frame_valid <= done;

      if (done) begin
        frame_seg       <= shadow_seg_reg;
        frame_hex       <= shadow_hex_reg;
        frame_ok        <= shadow_ok_reg;
        timeout_cnt_reg <= '0;
      end else if (timeout_cnt_reg != TO_MAX) begin
        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: active-low scans, short dwell, multi-hot,
// bad glyph, digit recapture, reset mid-frame and stale timing.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cathodes = 8'hFF;
  logic [7:0]  anodes = 8'hFF;
  logic [63:0] frame_seg;
  logic [31:0] frame_hex;
  logic [7:0]  frame_ok;
  logic        frame_valid, err_multi, stale;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .DIGITS(8), .SETTLE(4), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .cathodes(cathodes), .anodes(anodes),
    .frame_seg(frame_seg), .frame_hex(frame_hex), .frame_ok(frame_ok),
    .frame_valid(frame_valid), .err_multi(err_multi), .stale(stale)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, fv_count = 0, em_count = 0, fv_cyc = -1, stale_rise = -1;
  logic stale_q = 1'b0;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int scan1 [8] = '{0, 1, 2, 3, 10, 11, 12, 13};

  always @(negedge clk) begin
    cyc++;
    if (frame_valid) begin
      fv_count++;
      fv_cyc = cyc;
    end
    if (err_multi) em_count++;
    if (stale && !stale_q) stale_rise = cyc;
    stale_q = stale;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s ok value=%0h", tag, got);
    end
  endtask

  // Light one digit (active-low lines) for dwell cycles, then a 2-cycle blank.
  task automatic show(input int d, input logic [7:0] seg, input int dwell);
    anodes   = ~(8'd1 << d);
    cathodes = ~seg;
    repeat (dwell) @(negedge clk);
    anodes   = 8'hFF;
    cathodes = 8'hFF;
    repeat (2) @(negedge clk);
    $display("show digit=%0d seg=%02h dwell=%0d", d, seg, dwell);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int em0;
    int d_list [6];
    d_list = '{1, 3, 4, 5, 6, 7};

    repeat (4) @(negedge clk);
    check("rst_seg",   frame_seg,   64'd0);
    check("rst_hex",   frame_hex,   64'd0);
    check("rst_ok",    frame_ok,    64'd0);
    check("rst_valid", frame_valid, 64'd0);
    check("rst_multi", err_multi,   64'd0);
    check("rst_stale", stale,       64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: "0123ABCD"
    base = fv_count;
    for (int i = 0; i < 8; i++) show(i, glyph[scan1[i]], 16);
    repeat (6) @(negedge clk);
    check("f1_valid_cnt", 64'(fv_count - base), 64'd1);
    check("f1_hex",   frame_hex, 64'hDCBA3210);
    check("f1_ok",    frame_ok,  64'hFF);
    check("f1_seg",   frame_seg, 64'h5E397C774F5B063F);
    check("f1_stale", stale,     64'd0);

    // Frame 2: bad glyph on digit 2, short dwell on digit 3, digit 5 rescanned
    show(0, glyph[0], 16);
    show(1, glyph[1], 16);
    show(2, 8'h49, 16);
    show(3, glyph[3], 2);
    show(5, glyph[6], 16);
    show(4, glyph[4], 16);
    show(5, glyph[9], 16);
    show(6, glyph[6], 16);
    show(7, glyph[7], 16);
    repeat (6) @(negedge clk);
    check("short_dwell_no_frame", 64'(fv_count - base), 64'd1);
    show(3, glyph[3], 16);
    repeat (6) @(negedge clk);
    check("f2_valid_cnt", 64'(fv_count - base), 64'd2);
    check("f2_hex",    frame_hex,         64'h76943010);
    check("f2_ok",     frame_ok,          64'hFB);
    check("f2_seg2",   frame_seg[23:16],  64'h49);
    check("f2_seg5",   frame_seg[47:40],  64'h6F);

    // Multi-hot anodes (normalised 0000_0101) held 10 cycles
    em0 = em_count;
    anodes   = 8'hFA;
    cathodes = ~glyph[8];
    repeat (10) @(negedge clk);
    anodes   = 8'hFF;
    cathodes = 8'hFF;
    repeat (4) @(negedge clk);
    check("multi_pulse_cnt", 64'(em_count - em0), 64'd1);
    foreach (d_list[k]) show(d_list[k], glyph[8], 16);
    repeat (6) @(negedge clk);
    check("multi_no_seen", 64'(fv_count - base), 64'd2);

    // Reset mid-frame, then a full scan and idle until stale
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hex", frame_hex, 64'd0);
    check("midrst_ok",  frame_ok,  64'd0);
    check("midrst_seg", frame_seg, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    base = fv_count;
    for (int i = 0; i < 7; i++) show(i, glyph[i + 8], 16);
    repeat (6) @(negedge clk);
    check("midrst_seen_cleared", 64'(fv_count - base), 64'd0);
    show(7, glyph[15], 16);
    repeat (4) @(negedge clk);
    check("f3_valid_cnt", 64'(fv_count - base), 64'd1);
    check("f3_hex", frame_hex, 64'hFEDCBA98);
    for (int k = 0; k < 120 && !stale; k++) @(negedge clk);
    @(negedge clk);
    check("stale_high", stale, 64'd1);
    check("stale_delay", 64'(stale_rise - fv_cyc), 64'd64);
    check("f3_single_valid", 64'(fv_count - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
